// File: rtl/dma_axi_pkg.sv
// Shared AXI constants, FSM state encoding and helpers for the DMA read burster.
package dma_axi_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam int         AXI_4K     = 4096;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // AXI size encoding: log2 of bytes per beat.
  function automatic logic [2:0] size_log2(input int data_w);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if ((1 << i) == (data_w / 8)) r = 3'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/axi_burst_sizer.sv
// Beat count of the next INCR burst: min(MAX_BURST, words left, beats to the 4 KB edge).
module axi_burst_sizer
  import dma_axi_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 20,
  parameter int MAX_BURST = 16
) (
  input  logic [11:0]      i_addr_lo,
  input  logic [LEN_W-1:0] i_words_left,
  output logic [8:0]       o_burst
);

  localparam int         SHIFT  = int'(size_log2(DATA_W));
  localparam logic [12:0] MAXB  = 13'(MAX_BURST);

  logic [12:0] w_bytes_to_4k;
  logic [12:0] w_beats_to_4k;
  logic [31:0] w_words_ext;
  logic [12:0] w_words13;
  logic [12:0] w_min;

  assign w_bytes_to_4k = 13'(AXI_4K) - {1'b0, i_addr_lo};
  assign w_beats_to_4k = w_bytes_to_4k >> SHIFT;

  // Anything beyond 13 bits already exceeds every other bound, so saturate.
  assign w_words_ext = 32'(i_words_left);
  assign w_words13   = (w_words_ext > 32'd8191) ? 13'h1FFF : 13'(w_words_ext);

  always_comb begin
    w_min = MAXB;
    if (w_words13 < w_min)     w_min = w_words13;
    if (w_beats_to_4k < w_min) w_min = w_beats_to_4k;
  end

  assign o_burst = 9'(w_min);

endmodule

// File: rtl/dma_axi_read_burster.sv
// Turns one DMA databus read transfer into a chain of AXI4 INCR read bursts.
// Handshakes: AR transfers when m_arvalid & m_arready at a rising edge; R beats transfer
// when m_rvalid & m_rready; s_ready is a one-cycle data strobe with no backpressure.
module dma_axi_read_burster
  import dma_axi_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 20,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [LEN_W-1:0]  s_len,
  output logic              s_ready,
  output logic [DATA_W-1:0] s_rdata,
  output logic              s_last,
  output logic [ADDR_W-1:0] m_araddr,
  output logic              m_arvalid,
  input  logic              m_arready,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_rvalid,
  output logic              m_rready,
  input  logic              m_rlast,
  input  logic [1:0]        m_rresp,
  output logic              error,
  output logic [1:0]        o_dbg_state
);

  localparam logic [2:0] SIZE  = size_log2(DATA_W);
  localparam int         SHIFT = int'(SIZE);
  localparam int         BYTES = DATA_W / 8;

  state_e             r_state;
  state_e             w_next_state;
  logic [ADDR_W-1:0]  r_cur_addr;
  logic [LEN_W-1:0]   r_words_left;
  logic [8:0]         r_beats_in_burst;
  logic [8:0]         r_beat_cnt;
  logic               r_error;
  logic               r_zero_pulse;
  logic [8:0]         w_burst;
  logic               w_beat;
  logic               w_last_word;

  axi_burst_sizer #(
    .DATA_W    (DATA_W),
    .LEN_W     (LEN_W),
    .MAX_BURST (MAX_BURST)
  ) u_sizer (
    .i_addr_lo    (r_cur_addr[11:0]),
    .i_words_left (r_words_left),
    .o_burst      (w_burst)
  );

  assign w_beat      = (r_state == ST_DATA) && m_rvalid;
  assign w_last_word = (r_words_left == LEN_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (s_valid) w_next_state = (s_len == '0) ? ST_DONE : ST_ADDR;
      ST_ADDR: if (m_arready) w_next_state = ST_DATA;
      ST_DATA: if (w_beat && m_rlast) w_next_state = w_last_word ? ST_DONE : ST_ADDR;
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cur_addr       <= '0;
      r_words_left     <= '0;
      r_beats_in_burst <= '0;
      r_beat_cnt       <= '0;
      r_error          <= 1'b0;
      r_zero_pulse     <= 1'b0;
    end else begin
      // A zero-length request answers with a lone strobe during DONE.
      r_zero_pulse <= (r_state == ST_IDLE) && s_valid && (s_len == '0);
      case (r_state)
        ST_IDLE: begin
          if (s_valid) begin
            r_cur_addr   <= s_addr;
            r_words_left <= s_len >> SHIFT;
            r_error      <= 1'b0;
          end
        end
        ST_ADDR: begin
          if (m_arready) begin
            r_beats_in_burst <= w_burst;
            r_beat_cnt       <= '0;
          end
        end
        ST_DATA: begin
          if (w_beat) begin
            r_words_left <= r_words_left - LEN_W'(1);
            r_cur_addr   <= r_cur_addr + ADDR_W'(BYTES);
            r_beat_cnt   <= r_beat_cnt + 9'd1;
            if (m_rresp != RESP_OKAY) r_error <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    s_ready   = 1'b0;
    s_rdata   = '0;
    s_last    = 1'b0;
    m_araddr  = '0;
    m_arvalid = 1'b0;
    m_arlen   = '0;
    m_arsize  = SIZE;
    m_arburst = BURST_INCR;
    m_rready  = 1'b0;
    case (r_state)
      ST_ADDR: begin
        m_arvalid = 1'b1;
        m_araddr  = r_cur_addr;
        m_arlen   = 8'(w_burst - 9'd1);
      end
      ST_DATA: begin
        m_rready = 1'b1;
        s_ready  = m_rvalid;
        s_rdata  = m_rvalid ? m_rdata : '0;
        s_last   = m_rvalid && w_last_word;
      end
      ST_DONE: begin
        s_ready = r_zero_pulse;
        s_last  = r_zero_pulse;
      end
      default: ;
    endcase
  end

  assign error       = r_error;
  assign o_dbg_state = r_state;

`ifndef SYNTHESIS
  a_rlast_position: assert property (@(posedge clk) disable iff (rst)
    (r_state == ST_DATA && m_rvalid) |-> (m_rlast == (r_beat_cnt == r_beats_in_burst - 9'd1)))
    else $error("rlast does not match the requested burst length");
`endif

endmodule
